dcpu16_decode: RTL

Instruction-decode stage for the DCPU-16 (spec 1.1) model. It sits directly downstream of the fetch/loader path and upstream of the execute stage that drives `step()`/`dumpstate()`. It accepts a stream of 16-bit memory words and assembles each 1–3-word instruction. It emits one decoded instruction per handshake and halts on an illegal opcode, so the bench can treat 0x3FF0 as the success terminator.

---
 rtl/dcpu16_pkg.sv | 48 ++++
 rtl/dcpu16_operand_len.sv | 23 ++
 rtl/dcpu16_decode.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dcpu16_pkg.sv
// DCPU-16 (1.1) opcode and operand-code definitions shared by decode and execute.
package dcpu16_pkg;

    typedef enum logic [3:0] {
        OpNonBasic = 4'h0,
        OpSet      = 4'h1,
        OpAdd      = 4'h2,
        OpSub      = 4'h3,
        OpMul      = 4'h4,
        OpDiv      = 4'h5,
        OpMod      = 4'h6,
        OpShl      = 4'h7,
        OpShr      = 4'h8,
        OpAnd      = 4'h9,
        OpBor      = 4'hA,
        OpXor      = 4'hB,
        OpIfe      = 4'hC,
        OpIfn      = 4'hD,
        OpIfg      = 4'hE,
        OpIfb      = 4'hF
    } basic_op_e;

    typedef enum logic [5:0] {
        NbReserved = 6'h00,
        NbJsr      = 6'h01
    } nonbasic_op_e;

    // Operand-code bases; REG/IND/IND_NW span eight registers each, LIT spans 0x20-0x3F.
    localparam logic [5:0] REG       = 6'h00;
    localparam logic [5:0] IND       = 6'h08;
    localparam logic [5:0] IND_NW    = 6'h10;
    localparam logic [5:0] POP       = 6'h18;
    localparam logic [5:0] PEEK      = 6'h19;
    localparam logic [5:0] PUSH      = 6'h1A;
    localparam logic [5:0] SP        = 6'h1B;
    localparam logic [5:0] PC        = 6'h1C;
    localparam logic [5:0] O         = 6'h1D;
    localparam logic [5:0] IND_NWORD = 6'h1E;
    localparam logic [5:0] NWORD     = 6'h1F;
    localparam logic [5:0] LIT       = 6'h20;

    localparam logic [15:0] ILLEGAL_SUCCESS = 16'h3FF0;

    function automatic logic needs_next_word(input logic [5:0] code);
        return (code[5:3] == IND_NW[5:3]) || (code == IND_NWORD) || (code == NWORD);
    endfunction

endpackage

// File: rtl/dcpu16_operand_len.sv
// Combinational instruction-length decode for the first word of a DCPU-16 instruction.
module dcpu16_operand_len
    import dcpu16_pkg::*;
(
    input  logic [15:0] word_i,
    output logic        need_a_o,
    output logic        need_b_o,
    output logic        illegal_o,
    output logic [1:0]  len_o
);

    logic       nonbasic;
    logic [5:0] a_code;

    assign nonbasic  = (word_i[3:0] == OpNonBasic);
    assign a_code    = nonbasic ? word_i[15:10] : word_i[9:4];
    // Reserved non-basic opcodes are one word long; their operand is never fetched.
    assign illegal_o = nonbasic && (word_i[9:4] != NbJsr);
    assign need_a_o  = !illegal_o && needs_next_word(a_code);
    assign need_b_o  = !nonbasic && needs_next_word(word_i[15:10]);
    assign len_o     = 2'd1 + {1'b0, need_a_o} + {1'b0, need_b_o};

endmodule

// File: rtl/dcpu16_decode.sv
// DCPU-16 decode stage: assembles 1-3 word instructions and halts on a reserved opcode.
module dcpu16_decode
    import dcpu16_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_op,
    output logic [5:0]       out_nbop,
    output logic [5:0]       out_a,
    output logic [5:0]       out_b,
    output logic [15:0]      out_a_word,
    output logic [15:0]      out_b_word,
    output logic [1:0]       out_len,
    output logic             out_illegal,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {StOp, StNextA, StNextB, StValid, StHalt} state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [5:0]        nbop_q, nbop_d;
    logic [5:0]        a_q, a_d;
    logic [5:0]        b_q, b_d;
    logic [15:0]       a_word_q, a_word_d;
    logic [15:0]       b_word_q, b_word_d;
    logic [1:0]        len_q, len_d;
    logic              illegal_q, illegal_d;
    logic              valid_q, valid_d;
    logic              need_b_q, need_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic       need_a, need_b, illegal;
    logic [1:0] len;
    logic       nonbasic;
    logic       in_hs;

    dcpu16_operand_len u_operand_len (
        .word_i    (in_word),
        .need_a_o  (need_a),
        .need_b_o  (need_b),
        .illegal_o (illegal),
        .len_o     (len)
    );

    assign nonbasic = (in_word[3:0] == OpNonBasic);
    assign in_ready = reset_n && !flush &&
                      (state_q == StOp || state_q == StNextA || state_q == StNextB);
    assign in_hs    = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        nbop_d    = nbop_q;
        a_d       = a_q;
        b_d       = b_q;
        a_word_d  = a_word_q;
        b_word_d  = b_word_q;
        len_d     = len_q;
        illegal_d = illegal_q;
        valid_d   = valid_q;
        need_b_d  = need_b_q;
        cnt_d     = cnt_q;
        if (flush) begin
            state_d   = StOp;
            op_d      = '0;
            nbop_d    = '0;
            a_d       = '0;
            b_d       = '0;
            a_word_d  = '0;
            b_word_d  = '0;
            len_d     = '0;
            illegal_d = 1'b0;
            valid_d   = 1'b0;
            need_b_d  = 1'b0;
        end else begin
            unique case (state_q)
                StOp: begin
                    if (in_hs) begin
                        op_d      = in_word[3:0];
                        nbop_d    = nonbasic ? in_word[9:4] : 6'h00;
                        a_d       = nonbasic ? in_word[15:10] : in_word[9:4];
                        b_d       = nonbasic ? 6'h00 : in_word[15:10];
                        a_word_d  = '0;
                        b_word_d  = '0;
                        len_d     = len;
                        illegal_d = illegal;
                        need_b_d  = need_b;
                        if (need_a) begin
                            state_d = StNextA;
                        end else if (need_b) begin
                            state_d = StNextB;
                        end else begin
                            state_d = StValid;
                            valid_d = 1'b1;
                        end
                    end
                end
                StNextA: begin
                    if (in_hs) begin
                        a_word_d = in_word;
                        if (need_b_q) begin
                            state_d = StNextB;
                        end else begin
                            state_d = StValid;
                            valid_d = 1'b1;
                        end
                    end
                end
                StNextB: begin
                    if (in_hs) begin
                        b_word_d = in_word;
                        state_d  = StValid;
                        valid_d  = 1'b1;
                    end
                end
                StValid: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = illegal_q ? StHalt : StOp;
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StOp;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StOp;
            op_q      <= '0;
            nbop_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            a_word_q  <= '0;
            b_word_q  <= '0;
            len_q     <= '0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
            need_b_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            nbop_q    <= nbop_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_word_q  <= a_word_d;
            b_word_q  <= b_word_d;
            len_q     <= len_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
            need_b_q  <= need_b_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_op      = op_q;
    assign out_nbop    = nbop_q;
    assign out_a       = a_q;
    assign out_b       = b_q;
    assign out_a_word  = a_word_q;
    assign out_b_word  = b_word_q;
    assign out_len     = len_q;
    assign out_illegal = illegal_q;
    assign halted      = (state_q == StHalt);
    assign instr_count = cnt_q;

endmodule
